// File: rtl/cmplx_mult_fx.sv
// Four-stage fixed-point complex multiplier with per-sample conjugate,
// round-half-up, selectable saturation and per-sample plus sticky overflow.
module cmplx_mult_fx #(
    parameter int W    = 16,
    parameter int FRAC = 15,
    parameter int SAT  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           in_valid,
    input  logic           conj,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    input  logic           clr_sticky,
    output logic           out_valid,
    output logic [2*W-1:0] result,
    output logic           ovf,
    output logic           ovf_sticky
);

    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;
    localparam int RW = 2 * W + 2;

    localparam logic signed [RW-1:0] MAXV = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};
    // Half an output LSB; evaluates to zero when FRAC is zero.
    localparam logic signed [RW-1:0] RND  = (RW'(1) << FRAC) >> 1;

    logic [PW-1:0] a_q, b_q;
    logic          conj1_q, v1_q;

    logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
    logic                 conj2_q, v2_q;

    logic signed [SW-1:0] re_q, im_q;
    logic signed [SW-1:0] re_d, im_d;
    logic                 v3_q;

    logic [PW-1:0] res_q, res_d;
    logic          ovf_q, ovf_d;
    logic          v4_q;
    logic          sticky_q;

    logic signed [W-1:0] ar, ai, br, bi;
    logic [W:0]          re_fx, im_fx;

    assign ar = a_q[2*W-1:W];
    assign ai = a_q[W-1:0];
    assign br = b_q[2*W-1:W];
    assign bi = b_q[W-1:0];

    assign rr_d = ar * br;
    assign ii_d = ar * 0 + ai * bi;
    assign ri_d = ar * bi;
    assign ir_d = ai * br;

    always_comb begin
        logic signed [SW-1:0] rr_e, ii_e, ri_e, ir_e;
        rr_e = {rr_q[PW-1], rr_q};
        ii_e = {ii_q[PW-1], ii_q};
        ri_e = {ri_q[PW-1], ri_q};
        ir_e = {ir_q[PW-1], ir_q};
        re_d = rr_e - ii_e;
        im_d = ri_e + ir_e;
        if (conj2_q) begin
            re_d = rr_e + ii_e;
            im_d = ir_e - ri_e;
        end
    end

    // Returns {overflow, W-bit value} for one rounded, range-limited component.
    function automatic logic [W:0] fix(input logic signed [SW-1:0] x);
        logic signed [RW-1:0] t;
        logic signed [RW-1:0] s;
        logic                 o;
        logic [W-1:0]         v;
        t = {x[SW-1], x} + RND;
        s = t >>> FRAC;
        o = (s > MAXV) || (s < MINV);
        v = s[W-1:0];
        if (o && (SAT != 0))
            v = s[RW-1] ? MINV[W-1:0] : MAXV[W-1:0];
        return {o, v};
    endfunction

    always_comb begin
        re_fx = fix(re_q);
        im_fx = fix(im_q);
        res_d = {re_fx[W-1:0], im_fx[W-1:0]};
        ovf_d = re_fx[W] | im_fx[W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            conj1_q <= 1'b0;
            v1_q    <= 1'b0;
            rr_q    <= '0;
            ii_q    <= '0;
            ri_q    <= '0;
            ir_q    <= '0;
            conj2_q <= 1'b0;
            v2_q    <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            v3_q    <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            v4_q    <= 1'b0;
        end else if (ce) begin
            a_q     <= a;
            b_q     <= b;
            conj1_q <= conj;
            v1_q    <= in_valid;
            rr_q    <= rr_d;
            ii_q    <= ii_d;
            ri_q    <= ri_d;
            ir_q    <= ir_d;
            conj2_q <= conj1_q;
            v2_q    <= v1_q;
            re_q    <= re_d;
            im_q    <= im_d;
            v3_q    <= v2_q;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            v4_q    <= v3_q;
        end
    end

    // A set on the same edge as a clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_q <= 1'b0;
        else if (ce && v3_q && ovf_d)
            sticky_q <= 1'b1;
        else if (clr_sticky)
            sticky_q <= 1'b0;
    end

    assign out_valid  = v4_q;
    assign result     = res_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_cmplx_mult_fx.sv
// Directed self-checking bench for cmplx_mult_fx (W=16, FRAC=15),
// with a saturating and a wrapping instance sharing the same stimulus.
module tb_cmplx_mult_fx;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        in_valid;
    logic        conj;
    logic [31:0] a;
    logic [31:0] b;
    logic        clr_sticky;
    logic        out_valid;
    logic [31:0] result;
    logic        ovf;
    logic        ovf_sticky;
    logic        out_valid_w;
    logic [31:0] result_w;
    logic        ovf_w;
    logic        ovf_sticky_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmplx_mult_fx #(.W(16), .FRAC(15), .SAT(1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .conj(conj),
        .a(a), .b(b), .clr_sticky(clr_sticky), .out_valid(out_valid),
        .result(result), .ovf(ovf), .ovf_sticky(ovf_sticky)
    );

    cmplx_mult_fx #(.W(16), .FRAC(15), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .conj(conj),
        .a(a), .b(b), .clr_sticky(clr_sticky), .out_valid(out_valid_w),
        .result(result_w), .ovf(ovf_w), .ovf_sticky(ovf_sticky_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; in_valid = 1'b1; conj = 1'b0;
        a = 32'h40004000; b = 32'h40004000; clr_sticky = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
            $display("FAIL reset_async v=%b r=%h o=%b s=%b exp 0", out_valid, result, ovf, ovf_sticky);
            errors++;
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0) begin
            $display("FAIL reset_held v=%b r=%h exp 0", out_valid, result);
            errors++;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        a = 32'h40004000; b = 32'h4000C000; conj = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_early out_valid=%b exp 0", out_valid);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h40000000 || ovf !== 1'b0) begin
            $display("FAIL basic v=%b r=%h o=%b exp 1 40000000 0", out_valid, result, ovf);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_once out_valid=%b exp 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_conj();
        a = 32'h40004000; b = 32'h40004000; conj = 1'b0; in_valid = 1'b1;
        step();
        conj = 1'b1;
        step();
        in_valid = 1'b0; conj = 1'b0;
        step(); step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h00004000) begin
            $display("FAIL conj0 v=%b r=%h exp 1 00004000", out_valid, result);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h40000000) begin
            $display("FAIL conj1 v=%b r=%h exp 1 40000000", out_valid, result);
            errors++;
        end
        step();
    endtask

    task automatic test_saturation();
        a = 32'h80000000; b = 32'h80000000; conj = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            $display("FAIL sat_sticky_pre got=%b exp 0", ovf_sticky);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h7FFF0000 || ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
            $display("FAIL sat v=%b r=%h o=%b s=%b exp 1 7fff0000 1 1", out_valid, result, ovf, ovf_sticky);
            errors++;
        end
        checks++;
        if (out_valid_w !== 1'b1 || result_w !== 32'h80000000 || ovf_w !== 1'b1) begin
            $display("FAIL wrap v=%b r=%h o=%b exp 1 80000000 1", out_valid_w, result_w, ovf_w);
            errors++;
        end
        step();
    endtask

    task automatic test_rounding();
        a = 32'h00010000; b = 32'h40000000; conj = 1'b0; in_valid = 1'b1;
        step();
        a = 32'hFFFF0000;
        step();
        in_valid = 1'b0;
        step(); step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h00010000 || ovf !== 1'b0) begin
            $display("FAIL round_up v=%b r=%h o=%b exp 1 00010000 0", out_valid, result, ovf);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h00000000 || ovf !== 1'b0) begin
            $display("FAIL round_neg v=%b r=%h o=%b exp 1 00000000 0", out_valid, result, ovf);
            errors++;
        end
        step();
    endtask

    task automatic test_stall_bubbles();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vr [8];
        logic        vc [8];
        int          q[$];
        int          sent;
        int          got;
        int          idx;
        logic [31:0] held_r;
        logic        held_v;
        logic        held_o;
        va[0] = 32'h40004000; vb[0] = 32'h4000C000; vc[0] = 1'b0; vr[0] = 32'h40000000;
        va[1] = 32'h40004000; vb[1] = 32'h40004000; vc[1] = 1'b0; vr[1] = 32'h00004000;
        va[2] = 32'h40004000; vb[2] = 32'h40004000; vc[2] = 1'b1; vr[2] = 32'h40000000;
        va[3] = 32'h00010000; vb[3] = 32'h40000000; vc[3] = 1'b0; vr[3] = 32'h00010000;
        va[4] = 32'hFFFF0000; vb[4] = 32'h40000000; vc[4] = 1'b0; vr[4] = 32'h00000000;
        va[5] = 32'h20000000; vb[5] = 32'h40000000; vc[5] = 1'b0; vr[5] = 32'h10000000;
        va[6] = 32'h00004000; vb[6] = 32'h00004000; vc[6] = 1'b0; vr[6] = 32'hE0000000;
        va[7] = 32'h40000000; vb[7] = 32'h00002000; vc[7] = 1'b1; vr[7] = 32'h0000F000;
        sent = 0;
        got = 0;
        for (int c = 0; c < 80; c++) begin
            ce = !((c % 5 == 3) || (c % 7 == 2));
            in_valid = (sent < 8) && (c % 3 != 1);
            if (sent < 8) begin
                a = va[sent]; b = vb[sent]; conj = vc[sent];
            end
            held_r = result; held_v = out_valid; held_o = ovf;
            step();
            if (ce && in_valid) begin
                q.push_back(sent);
                sent++;
            end
            if (!ce) begin
                checks++;
                if (out_valid !== held_v || result !== held_r || ovf !== held_o) begin
                    $display("FAIL stall_hold c=%0d v=%b r=%h exp %b %h", c, out_valid, result, held_v, held_r);
                    errors++;
                end
            end else if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL stall_extra c=%0d r=%h exp no output", c, result);
                    errors++;
                end else begin
                    idx = q.pop_front();
                    got++;
                    if (result !== vr[idx] || ovf !== 1'b0) begin
                        $display("FAIL stall_data s=%0d r=%h o=%b exp %h 0", idx, result, ovf, vr[idx]);
                        errors++;
                    end
                end
            end
        end
        ce = 1'b1;
        in_valid = 1'b0;
        checks++;
        if (got != 8 || q.size() != 0) begin
            $display("FAIL stall_count got=%0d pending=%0d exp 8 0", got, q.size());
            errors++;
        end
    endtask

    task automatic test_sticky();
        checks++;
        if (ovf_sticky !== 1'b1) begin
            $display("FAIL sticky_hold got=%b exp 1", ovf_sticky);
            errors++;
        end
        ce = 1'b0; clr_sticky = 1'b1;
        step();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            $display("FAIL sticky_clr got=%b exp 0", ovf_sticky);
            errors++;
        end
        ce = 1'b1; clr_sticky = 1'b0;
        a = 32'h80000000; b = 32'h80000000; conj = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        clr_sticky = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
            $display("FAIL sticky_set_wins v=%b o=%b s=%b exp 1 1 1", out_valid, ovf, ovf_sticky);
            errors++;
        end
        step();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            $display("FAIL sticky_clr_after got=%b exp 0", ovf_sticky);
            errors++;
        end
        clr_sticky = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        logic bad;
        a = 32'h80000000; b = 32'h80000000; conj = 1'b0; in_valid = 1'b1;
        step();
        a = 32'h40004000; b = 32'h4000C000;
        step(); step(); step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ovf_sticky !== 1'b1) begin
            $display("FAIL mid_pre v=%b s=%b exp 1 1", out_valid, ovf_sticky);
            errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
            $display("FAIL mid_rst v=%b r=%h o=%b s=%b exp 0", out_valid, result, ovf, ovf_sticky);
            errors++;
        end
        step();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            $display("FAIL mid_discard out_valid seen=1 exp 0");
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conj();
        test_saturation();
        test_rounding();
        test_stall_bubbles();
        test_sticky();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
